// File: rtl/fix_pkg.sv
// rtl/fix_pkg.sv - shared state type, EOM constant and round-robin pick function for the FIX TX arbiter
package fix_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        XFER  = 2'd1,
        ABORT = 2'd2
    } arb_state_t;

    localparam logic [7:0] FIX_EOM      = 8'h3B;
    localparam int         FIX_MAX_SESS = 8;

    // First set bit of req at or after ptr, wrapping within the n live requesters.
    function automatic logic [2:0] rr_pick(input logic [7:0] req, input logic [2:0] ptr, input int n);
        logic [2:0] pick;
        logic       found;
        int         idx;
        pick  = 3'd0;
        found = 1'b0;
        for (int i = 0; i < FIX_MAX_SESS; i++) begin
            idx = int'(ptr) + i;
            if (idx >= n) begin
                idx = idx - n;
            end
            if ((i < n) && !found && req[idx[2:0]]) begin
                pick  = idx[2:0];
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/fix_rr_picker.sv
// rtl/fix_rr_picker.sv - combinational round-robin priority pick over the session request mask
module fix_rr_picker
    import fix_pkg::*;
#(
    parameter int N = 4,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req_i,
    input  logic [W-1:0] ptr_i,
    output logic [W-1:0] gnt_o,
    output logic         any_o
);

    logic [7:0] req_ext;
    logic [2:0] ptr_ext;
    logic [2:0] pick;

    // Widen to the package function's fixed eight-requester form, then pick.
    always_comb begin
        req_ext          = '0;
        req_ext[N-1:0]   = req_i;
        ptr_ext          = '0;
        ptr_ext[W-1:0]   = ptr_i;
        pick             = rr_pick(req_ext, ptr_ext, N);
        gnt_o            = W'(pick);
        any_o            = |req_i;
    end

endmodule

// File: rtl/fix_tx_session_arbiter.sv
// rtl/fix_tx_session_arbiter.sv - message-granular round-robin arbiter of FIX sessions onto the TX byte channel (optional FIX_ARB_STATS_EN)
module fix_tx_session_arbiter
    import fix_pkg::*;
#(
    parameter int              N_SESS      = 4,
    parameter int              DW          = 8,
    parameter logic [DW-1:0]   EOM_BYTE    = DW'(FIX_EOM),
    parameter int              MAX_MSG_LEN = 256
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [N_SESS-1:0]            sess_valid_i,
    input  logic [N_SESS*DW-1:0]         sess_data_i,
    output logic [N_SESS-1:0]            sess_ready_o,
    input  logic [N_SESS-1:0]            connected_i,
    input  logic                         message_ready_i,
    output logic                         send_message_valid_o,
    output logic [DW-1:0]                message_o,
    output logic [$clog2(N_SESS)-1:0]    host_num_o,
    output logic                         msg_start_o,
    output logic                         abort_o
`ifdef FIX_ARB_STATS_EN
    ,
    output logic [N_SESS*16-1:0]         msg_count_o
`endif
);

    localparam int HW = $clog2(N_SESS);
    localparam int CW = $clog2(MAX_MSG_LEN);
    localparam logic [CW-1:0] CNT_LAST = CW'(MAX_MSG_LEN - 1);
    localparam logic [HW-1:0] GNT_LAST = HW'(N_SESS - 1);

    arb_state_t     state_q, state_d;
    logic [HW-1:0]  gnt_q, gnt_d;
    logic [HW-1:0]  rr_ptr_q, rr_ptr_d;
    logic [CW-1:0]  cnt_q, cnt_d;

    logic [DW-1:0]  sess_data_a [N_SESS];
    logic [N_SESS-1:0] req;
    logic [HW-1:0]  pick_gnt;
    logic           pick_any;

    logic           cur_valid;
    logic [DW-1:0]  cur_data;
    logic           cur_conn;
    logic           xfer_fire;
    logic           xfer_eom;
    logic [HW-1:0]  gnt_next;
    logic [CW-1:0]  cnt_inc;

    for (genvar k = 0; k < N_SESS; k++) begin : g_unpack
        assign sess_data_a[k] = sess_data_i[k*DW +: DW];
    end

    // Only connected sessions with a byte ready may win the channel.
    assign req = sess_valid_i & connected_i;

    fix_rr_picker #(
        .N (N_SESS),
        .W (HW)
    ) u_picker (
        .req_i (req),
        .ptr_i (rr_ptr_q),
        .gnt_o (pick_gnt),
        .any_o (pick_any)
    );

    assign cur_valid = sess_valid_i[gnt_q];
    assign cur_data  = sess_data_a[gnt_q];
    assign cur_conn  = connected_i[gnt_q];
    assign xfer_fire = (state_q == XFER) && cur_valid && message_ready_i;
    assign xfer_eom  = xfer_fire && (cur_data == EOM_BYTE);
    assign gnt_next  = (gnt_q == GNT_LAST) ? '0 : gnt_q + 1'b1;
    assign cnt_inc   = cnt_q + 1'b1;

    // Next-state and output decode: pass-through in XFER, injected EOM in ABORT.
    always_comb begin
        state_d              = state_q;
        gnt_d                = gnt_q;
        rr_ptr_d             = rr_ptr_q;
        cnt_d                = cnt_q;
        sess_ready_o         = '0;
        send_message_valid_o = 1'b0;
        message_o            = '0;
        host_num_o           = '0;
        msg_start_o          = 1'b0;
        abort_o              = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    gnt_d   = pick_gnt;
                    cnt_d   = '0;
                    state_d = XFER;
                end
            end
            XFER: begin
                send_message_valid_o = cur_valid;
                message_o            = cur_data;
                host_num_o           = gnt_q;
                msg_start_o          = cur_valid && (cnt_q == '0);
                sess_ready_o[gnt_q]  = message_ready_i;
                if (xfer_fire) begin
                    cnt_d = cnt_inc;
                    if (xfer_eom) begin
                        rr_ptr_d = gnt_next;
                        state_d  = IDLE;
                    end else if (cnt_inc == CNT_LAST) begin
                        state_d = ABORT;
                    end
                end
                // A lost connection ends the message unless this very byte closes it.
                if (!cur_conn && !xfer_eom) begin
                    state_d = ABORT;
                end
            end
            ABORT: begin
                send_message_valid_o = 1'b1;
                message_o            = EOM_BYTE;
                host_num_o           = gnt_q;
                if (message_ready_i) begin
                    abort_o  = 1'b1;
                    rr_ptr_d = gnt_next;
                    state_d  = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, grant, round-robin pointer and byte counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            gnt_q    <= '0;
            rr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            rr_ptr_q <= rr_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

`ifdef FIX_ARB_STATS_EN
    logic [15:0] msg_cnt_q [N_SESS];

    // Count messages closed by their own EOM; forced aborts are not counted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < N_SESS; k++) begin
                msg_cnt_q[k] <= '0;
            end
        end else if (xfer_eom) begin
            msg_cnt_q[gnt_q] <= msg_cnt_q[gnt_q] + 16'd1;
        end
    end

    for (genvar k = 0; k < N_SESS; k++) begin : g_stats
        assign msg_count_o[k*16 +: 16] = msg_cnt_q[k];
    end
`endif

endmodule

// File: tb/tb_fix_tx_session_arbiter.sv
// tb/tb_fix_tx_session_arbiter.sv - self-checking bench for fix_tx_session_arbiter
module tb_fix_tx_session_arbiter;

    localparam int         NS   = 4;
    localparam int         DW   = 8;
    localparam int         MAXL = 4;
    localparam logic [7:0] EOM  = 8'h3B;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [NS-1:0]     sess_valid_i;
    logic [NS*DW-1:0]  sess_data_i;
    logic [NS-1:0]     sess_ready_o;
    logic [NS-1:0]     connected_i;
    logic              message_ready_i;
    logic              send_message_valid_o;
    logic [DW-1:0]     message_o;
    logic [1:0]        host_num_o;
    logic              msg_start_o;
    logic              abort_o;
`ifdef FIX_ARB_STATS_EN
    logic [NS*16-1:0]  msg_count_o;
`endif

    fix_tx_session_arbiter #(
        .N_SESS      (NS),
        .DW          (DW),
        .EOM_BYTE    (EOM),
        .MAX_MSG_LEN (MAXL)
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
        .sess_valid_i         (sess_valid_i),
        .sess_data_i          (sess_data_i),
        .sess_ready_o         (sess_ready_o),
        .connected_i          (connected_i),
        .message_ready_i      (message_ready_i),
        .send_message_valid_o (send_message_valid_o),
        .message_o            (message_o),
        .host_num_o           (host_num_o),
        .msg_start_o          (msg_start_o),
        .abort_o              (abort_o)
`ifdef FIX_ARB_STATS_EN
        ,
        .msg_count_o          (msg_count_o)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [7:0]    src_q [NS][$];
    logic [NS-1:0] fire = '0;

    typedef struct {
        int         host;
        logic [7:0] data;
        bit         start;
        bit         abort;
        int         cyc;
    } xfer_t;
    xfer_t log_q[$];

    // Model: who owns the channel (-1 = nobody), whether it is being cut off, bytes sent so far.
    int m_owner = -1;
    bit m_abort = 1'b0;
    int m_cnt   = 0;
    int m_rr    = 0;

    logic          e_valid, e_start, e_abort;
    logic [7:0]    e_data;
    logic [1:0]    e_host;
    logic [NS-1:0] e_ready;

    always @(posedge clk) cyc <= cyc + 1;

    // Expected outputs for the current cycle.
    always_comb begin
        e_valid = 1'b0;
        e_data  = 8'h00;
        e_host  = 2'd0;
        e_start = 1'b0;
        e_abort = 1'b0;
        e_ready = '0;
        if (rst && m_owner >= 0) begin
            e_host = 2'(m_owner);
            if (m_abort) begin
                e_valid = 1'b1;
                e_data  = EOM;
                e_abort = message_ready_i;
            end else begin
                e_valid          = sess_valid_i[m_owner];
                e_data           = sess_data_i[m_owner*DW +: DW];
                e_ready[m_owner] = message_ready_i;
                e_start          = e_valid && (m_cnt == 0);
            end
        end
    end

    // Advance the model on each clock.
    always @(posedge clk or negedge rst) begin
        int nxt_owner, nxt_cnt, nxt_rr, k;
        bit nxt_abort, fire_m, eom_m;
        if (!rst) begin
            m_owner <= -1;
            m_abort <= 1'b0;
            m_cnt   <= 0;
            m_rr    <= 0;
        end else begin
            nxt_owner = m_owner;
            nxt_abort = m_abort;
            nxt_cnt   = m_cnt;
            nxt_rr    = m_rr;
            if (m_owner < 0) begin
                for (int i = 0; i < NS; i++) begin
                    k = (m_rr + i) % NS;
                    if (nxt_owner < 0 && sess_valid_i[k] && connected_i[k]) begin
                        nxt_owner = k;
                        nxt_cnt   = 0;
                        nxt_abort = 1'b0;
                    end
                end
            end else if (m_abort) begin
                if (message_ready_i) begin
                    nxt_owner = -1;
                    nxt_abort = 1'b0;
                    nxt_rr    = (m_owner + 1) % NS;
                end
            end else begin
                fire_m = sess_valid_i[m_owner] && message_ready_i;
                eom_m  = fire_m && (sess_data_i[m_owner*DW +: DW] == EOM);
                if (eom_m) begin
                    nxt_owner = -1;
                    nxt_rr    = (m_owner + 1) % NS;
                end else begin
                    if (fire_m) nxt_cnt = m_cnt + 1;
                    if (fire_m && nxt_cnt == MAXL - 1) nxt_abort = 1'b1;
                    if (!connected_i[m_owner]) nxt_abort = 1'b1;
                end
            end
            m_owner <= nxt_owner;
            m_abort <= nxt_abort;
            m_cnt   <= nxt_cnt;
            m_rr    <= nxt_rr;
        end
    end

    // Per-cycle compare, transfer log and source pop flags.
    always @(negedge clk) begin
        n_checks++;
        if ({send_message_valid_o, message_o, host_num_o, msg_start_o, abort_o, sess_ready_o} !==
            {e_valid, e_data, e_host, e_start, e_abort, e_ready}) begin
            n_fail++;
            $display("FAIL cycle_outputs cyc=%0d: got v=%b d=%h h=%0d s=%b a=%b r=%b, expected v=%b d=%h h=%0d s=%b a=%b r=%b",
                     cyc, send_message_valid_o, message_o, host_num_o, msg_start_o, abort_o, sess_ready_o,
                     e_valid, e_data, e_host, e_start, e_abort, e_ready);
        end
        if (send_message_valid_o && message_ready_i) begin
            log_q.push_back('{int'(host_num_o), message_o, msg_start_o, abort_o, cyc});
        end
        fire = sess_ready_o & sess_valid_i;
    end

    // Session sources: each presents the head of its byte queue.
    initial begin
        sess_valid_i = '0;
        sess_data_i  = '0;
        forever begin
            @(posedge clk);
            #1;
            for (int k = 0; k < NS; k++) begin
                if (fire[k] && src_q[k].size() > 0) void'(src_q[k].pop_front());
                sess_valid_i[k] = (src_q[k].size() > 0);
                sess_data_i[k*DW +: DW] = (src_q[k].size() > 0) ? src_q[k][0] : 8'h00;
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic push(input int s, input logic [7:0] b);
        src_q[s].push_back(b);
    endtask

    task automatic wait_log(input int n, input string name);
        int budget;
        budget = 60;
        while (log_q.size() < n && budget > 0) begin
            @(negedge clk);
            #1;
            budget--;
        end
        chk(name, 64'(log_q.size() >= n), 64'd1);
    endtask

    task automatic chk_log(input string name, input int idx, input logic [1:0] h, input logic [7:0] d,
                           input bit s, input bit a);
        logic [1:0] ah;
        if (idx >= log_q.size()) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: entry %0d missing, got %0d entries", name, idx, log_q.size());
        end else begin
            ah = 2'(log_q[idx].host);
            chk(name, {ah, log_q[idx].data, log_q[idx].start, log_q[idx].abort}, {h, d, s, a});
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        rst = 1'b0;
        for (int k = 0; k < NS; k++) src_q[k].delete();
        connected_i     = '0;
        message_ready_i = 1'b1;
        tick(2);
        rst = 1'b1;
        log_q.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int n0;
        connected_i     = '0;
        message_ready_i = 1'b1;
        @(negedge clk);
        #1;
        chk("reset_outputs", {send_message_valid_o, message_o, host_num_o, msg_start_o, abort_o, sess_ready_o}, 64'd0);

        // 1: single session, one idle arbitration cycle
        do_reset();
        connected_i = 4'b0010;
        n0 = cyc;
        push(1, 8'h41); push(1, 8'h42); push(1, EOM);
        wait_log(3, "t1_done");
        chk_log("t1_b0", 0, 2'd1, 8'h41, 1'b1, 1'b0);
        chk_log("t1_b1", 1, 2'd1, 8'h42, 1'b0, 1'b0);
        chk_log("t1_b2", 2, 2'd1, EOM,   1'b0, 1'b0);
        if (log_q.size() >= 3) begin
            chk("t1_latency", 64'(log_q[0].cyc), 64'(n0 + 2));
            chk("t1_back_to_back", 64'(log_q[2].cyc - log_q[0].cyc), 64'd2);
        end
        tick(4);
        chk("t1_no_extra", 64'(log_q.size()), 64'd3);

        // 2: round-robin between sessions 0 and 2
        do_reset();
        connected_i = 4'b0101;
        push(0, 8'h10); push(0, EOM); push(0, 8'h11); push(0, EOM);
        push(2, 8'h20); push(2, EOM); push(2, 8'h21); push(2, EOM);
        wait_log(8, "t2_done");
        chk_log("t2_b0", 0, 2'd0, 8'h10, 1'b1, 1'b0);
        chk_log("t2_b1", 1, 2'd0, EOM,   1'b0, 1'b0);
        chk_log("t2_b2", 2, 2'd2, 8'h20, 1'b1, 1'b0);
        chk_log("t2_b3", 3, 2'd2, EOM,   1'b0, 1'b0);
        chk_log("t2_b4", 4, 2'd0, 8'h11, 1'b1, 1'b0);
        chk_log("t2_b5", 5, 2'd0, EOM,   1'b0, 1'b0);
        chk_log("t2_b6", 6, 2'd2, 8'h21, 1'b1, 1'b0);
        chk_log("t2_b7", 7, 2'd2, EOM,   1'b0, 1'b0);

        // 3: backpressure mid-message
        do_reset();
        connected_i = 4'b0010;
        push(1, 8'h61); push(1, 8'h62); push(1, EOM);
        wait_log(1, "t3_first");
        tick(1);
        message_ready_i = 1'b0;
        repeat (5) begin
            @(negedge clk);
            #1;
            chk("t3_hold", {send_message_valid_o, message_o, host_num_o, sess_ready_o}, {1'b1, 8'h62, 2'd1, 4'b0000});
        end
        tick(1);
        message_ready_i = 1'b1;
        wait_log(3, "t3_done");
        tick(3);
        chk("t3_count", 64'(log_q.size()), 64'd3);
        chk_log("t3_b0", 0, 2'd1, 8'h61, 1'b1, 1'b0);
        chk_log("t3_b1", 1, 2'd1, 8'h62, 1'b0, 1'b0);
        chk_log("t3_b2", 2, 2'd1, EOM,   1'b0, 1'b0);

        // 4: length guard forces an injected EOM
        do_reset();
        connected_i = 4'b1001;
        repeat (5) push(3, 8'h55);
        wait_log(1, "t4_first");
        push(0, 8'h70); push(0, EOM);
        wait_log(6, "t4_done");
        chk_log("t4_b0", 0, 2'd3, 8'h55, 1'b1, 1'b0);
        chk_log("t4_b1", 1, 2'd3, 8'h55, 1'b0, 1'b0);
        chk_log("t4_b2", 2, 2'd3, 8'h55, 1'b0, 1'b0);
        chk_log("t4_abort", 3, 2'd3, EOM, 1'b0, 1'b1);
        chk_log("t4_next0", 4, 2'd0, 8'h70, 1'b1, 1'b0);
        chk_log("t4_next1", 5, 2'd0, EOM,   1'b0, 1'b0);

        // 5: disconnect mid-message
        do_reset();
        connected_i = 4'b0011;
        push(1, 8'h81); push(1, 8'h82); push(1, EOM);
        wait_log(1, "t5_first");
        tick(1);
        connected_i = 4'b0001;
        push(0, 8'h90); push(0, EOM);
        wait_log(5, "t5_done");
        tick(4);
        chk("t5_count", 64'(log_q.size()), 64'd5);
        chk_log("t5_b0", 0, 2'd1, 8'h81, 1'b1, 1'b0);
        chk_log("t5_b1", 1, 2'd1, 8'h82, 1'b0, 1'b0);
        chk_log("t5_abort", 2, 2'd1, EOM, 1'b0, 1'b1);
        chk_log("t5_next0", 3, 2'd0, 8'h90, 1'b1, 1'b0);
        chk_log("t5_next1", 4, 2'd0, EOM,   1'b0, 1'b0);

`ifdef FIX_ARB_STATS_EN
        // 6: completed-message counter excludes aborts
        do_reset();
        connected_i = 4'b0001;
        push(0, 8'hA1); push(0, EOM); push(0, 8'hA2); push(0, EOM); push(0, 8'hA3); push(0, EOM);
        push(0, 8'h55); push(0, 8'h55); push(0, 8'h55);
        wait_log(10, "t6_done");
        tick(2);
        chk_log("t6_abort", 9, 2'd0, EOM, 1'b0, 1'b1);
        chk("t6_count0", 64'(msg_count_o[15:0]), 64'd3);
        chk("t6_count_rest", 64'(msg_count_o[63:16]), 64'd0);
`endif

        // 7: asynchronous reset mid-message clears outputs at once
        do_reset();
        connected_i = 4'b0010;
        push(1, 8'h41); push(1, 8'h42); push(1, EOM);
        wait_log(1, "t7_first");
        tick(1);
        rst = 1'b0;
        #1;
        chk("t7_async_reset", {send_message_valid_o, message_o, host_num_o, msg_start_o, abort_o, sess_ready_o}, 64'd0);
        for (int k = 0; k < NS; k++) src_q[k].delete();
        tick(2);
        rst = 1'b1;
        tick(3);
        chk("t7_idle_after", 64'(send_message_valid_o), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
